// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem request, stall hold buffer and IF/ID register.
// Optional feature macro: FETCH_PERF_CNT_EN adds perf_fetched/perf_killed counters.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] next_pc,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic [31:0] ifid_instr,
    output logic        fetch_busy,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_killed,
`endif
    output logic [1:0]  state_dbg
);

    // Handshake: a request is accepted on the same edge imem_req is high; imem_rvalid
    // returns in order, at least one cycle later, and only one request is ever outstanding.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      state, state_next;
    logic [31:0] hold_data;
    logic        pc_load;
    logic        deliver;
    logic        use_hold;
    logic        ifid_kill;
    logic        hold_load;
    logic        resp_kill;
    logic [31:0] deliver_instr;

    assign pc4        = pc + 32'd4;
    assign imem_req   = (state == S_REQ);
    assign imem_addr  = pc;
    assign fetch_busy = (state == S_WAIT) || (state == S_DROP);
    assign state_dbg  = state;
    assign deliver_instr = use_hold ? hold_data : imem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_REQ;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        pc_load    = 1'b0;
        deliver    = 1'b0;
        use_hold   = 1'b0;
        ifid_kill  = 1'b0;
        hold_load  = 1'b0;
        resp_kill  = 1'b0;
        case (state)
            S_REQ: begin
                // The request still goes out on a flush, so its response must be dropped.
                if (flush) begin
                    pc_load    = 1'b1;
                    ifid_kill  = 1'b1;
                    state_next = S_DROP;
                end else begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    pc_load   = 1'b1;
                    ifid_kill = 1'b1;
                    if (imem_rvalid) begin
                        resp_kill  = 1'b1;
                        state_next = S_REQ;
                    end else begin
                        state_next = S_DROP;
                    end
                end else if (imem_rvalid && stall) begin
                    hold_load  = 1'b1;
                    state_next = S_HOLD;
                end else if (imem_rvalid) begin
                    deliver    = 1'b1;
                    pc_load    = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_DROP: begin
                if (flush) pc_load = 1'b1;
                if (imem_rvalid) begin
                    resp_kill  = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    pc_load    = 1'b1;
                    ifid_kill  = 1'b1;
                    resp_kill  = 1'b1;
                    state_next = S_REQ;
                end else if (!stall) begin
                    deliver    = 1'b1;
                    use_hold   = 1'b1;
                    pc_load    = 1'b1;
                    state_next = S_REQ;
                end
            end
            default: state_next = S_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            hold_data <= 32'd0;
        end else begin
            if (pc_load)   pc        <= next_pc;
            if (hold_load) hold_data <= imem_rdata;
        end
    end

    // Non-delivering cycles: stall freezes IF/ID, otherwise a bubble is inserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_valid <= 1'b0;
            ifid_pc    <= 32'd0;
            ifid_pc4   <= 32'd0;
            ifid_instr <= NOP_INSTR;
        end else if (deliver) begin
            ifid_valid <= 1'b1;
            ifid_pc    <= pc;
            ifid_pc4   <= pc4;
            ifid_instr <= deliver_instr;
        end else if (ifid_kill || !stall) begin
            ifid_valid <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= 32'd0;
            perf_killed  <= 32'd0;
        end else begin
            if (deliver)   perf_fetched <= perf_fetched + 32'd1;
            if (resp_kill) perf_killed  <= perf_killed + 32'd1;
        end
    end
`endif

endmodule
